// File: rtl/line_stream_generator.sv
// AXI4-Stream synthetic frame source: byte-ramp lines as 64-bit beats with
// SOF/EOF/SOL/EOL sync codes in tuser, tlast on each line's last beat.
module line_stream_generator #(
  parameter int XW = 16,
  parameter int YW = 16
) (
  input  logic          aclk,
  input  logic          aclk_reset,
  input  logic          aclk_start,
  input  logic [XW-1:0] aclk_x_size,
  input  logic [YW-1:0] aclk_y_size,
  input  logic [XW-1:0] aclk_line_gap,
  output logic          aclk_busy,
  output logic          aclk_frame_done,
  input  logic          aclk_tready,
  output logic          aclk_tvalid,
  output logic [3:0]    aclk_tuser,
  output logic          aclk_tlast,
  output logic [63:0]   aclk_tdata
);

  // state  | meaning
  // IDLE   | waiting for start, outputs quiet
  // LINE   | presenting beats of the current line
  // GAP    | tvalid held low for line_gap cycles between lines
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LINE = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam int BW = XW - 3;

  logic [1:0]    state;
  logic [BW-1:0] bpl_m1;
  logic [YW-1:0] lines_m1;
  logic [XW-1:0] gap_len;
  logic [BW-1:0] beat_cnt;
  logic [YW-1:0] line_cnt;
  logic [XW-1:0] gap_cnt;

  logic [BW-1:0] x_beats;
  logic [BW-1:0] in_bpl_m1;
  logic [YW-1:0] in_lines_m1;
  logic [BW-1:0] next_beat;
  logic [YW-1:0] next_line;
  logic          beat_last;
  logic          line_last;
  logic          unused_x_lsb;

  assign unused_x_lsb = ^aclk_x_size[2:0];
  assign x_beats      = aclk_x_size[XW-1:3];
  // Zero-sized dimensions degrade to a single beat / single line
  assign in_bpl_m1    = (x_beats == '0) ? '0 : x_beats - BW'(1);
  assign in_lines_m1  = (aclk_y_size == '0) ? '0 : aclk_y_size - YW'(1);
  assign next_beat    = beat_cnt + BW'(1);
  assign next_line    = line_cnt + YW'(1);
  assign beat_last    = (beat_cnt == bpl_m1);
  assign line_last    = (line_cnt == lines_m1);

  // Returns {tlast, tuser, tdata}; byte k of beat b is {b[4:0], k}, i.e. (8b+k) mod 256
  function automatic logic [68:0] beat_word(input logic [4:0] b5, input logic first,
                                            input logic last, input logic line0,
                                            input logic line_end);
    logic [63:0] d;
    logic [3:0]  u;
    for (int k = 0; k < 8; k++) d[8*k +: 8] = {b5, 3'(k)};
    u = {last & ~line_end, first & ~line0, last & line_end, first & line0};
    return {last, u, d};
  endfunction

  always_ff @(posedge aclk) begin
    if (aclk_reset) begin
      state           <= S_IDLE;
      bpl_m1          <= '0;
      lines_m1        <= '0;
      gap_len         <= '0;
      beat_cnt        <= '0;
      line_cnt        <= '0;
      gap_cnt         <= '0;
      aclk_busy       <= 1'b0;
      aclk_frame_done <= 1'b0;
      aclk_tvalid     <= 1'b0;
      aclk_tuser      <= '0;
      aclk_tlast      <= 1'b0;
      aclk_tdata      <= '0;
    end else begin
      aclk_frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (aclk_start) begin
            bpl_m1      <= in_bpl_m1;
            lines_m1    <= in_lines_m1;
            gap_len     <= aclk_line_gap;
            beat_cnt    <= '0;
            line_cnt    <= '0;
            aclk_busy   <= 1'b1;
            aclk_tvalid <= 1'b1;
            {aclk_tlast, aclk_tuser, aclk_tdata} <=
              beat_word(5'd0, 1'b1, in_bpl_m1 == '0, 1'b1, in_lines_m1 == '0);
            state       <= S_LINE;
          end
        end
        S_LINE: begin
          if (aclk_tvalid && aclk_tready) begin
            if (!beat_last) begin
              beat_cnt <= next_beat;
              {aclk_tlast, aclk_tuser, aclk_tdata} <=
                beat_word(next_beat[4:0], 1'b0, next_beat == bpl_m1, line_cnt == '0, line_last);
            end else if (line_last) begin
              state           <= S_IDLE;
              aclk_busy       <= 1'b0;
              aclk_frame_done <= 1'b1;
              aclk_tvalid     <= 1'b0;
              {aclk_tlast, aclk_tuser, aclk_tdata} <= '0;
            end else begin
              beat_cnt <= '0;
              line_cnt <= next_line;
              if (gap_len == '0) begin
                {aclk_tlast, aclk_tuser, aclk_tdata} <=
                  beat_word(5'd0, 1'b1, bpl_m1 == '0, 1'b0, next_line == lines_m1);
              end else begin
                state       <= S_GAP;
                gap_cnt     <= gap_len;
                aclk_tvalid <= 1'b0;
                {aclk_tlast, aclk_tuser, aclk_tdata} <= '0;
              end
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == XW'(1)) begin
            state       <= S_LINE;
            aclk_tvalid <= 1'b1;
            {aclk_tlast, aclk_tuser, aclk_tdata} <=
              beat_word(5'd0, 1'b1, bpl_m1 == '0, line_cnt == '0, line_last);
          end else begin
            gap_cnt <= gap_cnt - XW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_stream_generator.sv
// Bench for line_stream_generator: table of frame configurations checked
// through an expected-beat queue, plus start/reset corner sequences.
module tb_line_stream_generator;
  localparam int XW = 16;
  localparam int YW = 16;

  logic          aclk = 1'b0;
  logic          aclk_reset = 1'b1;
  logic          aclk_start = 1'b0;
  logic [XW-1:0] aclk_x_size = '0;
  logic [YW-1:0] aclk_y_size = '0;
  logic [XW-1:0] aclk_line_gap = '0;
  logic          aclk_busy;
  logic          aclk_frame_done;
  logic          aclk_tready = 1'b0;
  logic          aclk_tvalid;
  logic [3:0]    aclk_tuser;
  logic          aclk_tlast;
  logic [63:0]   aclk_tdata;

  line_stream_generator #(.XW(XW), .YW(YW)) dut (
    .aclk(aclk), .aclk_reset(aclk_reset), .aclk_start(aclk_start),
    .aclk_x_size(aclk_x_size), .aclk_y_size(aclk_y_size), .aclk_line_gap(aclk_line_gap),
    .aclk_busy(aclk_busy), .aclk_frame_done(aclk_frame_done), .aclk_tready(aclk_tready),
    .aclk_tvalid(aclk_tvalid), .aclk_tuser(aclk_tuser), .aclk_tlast(aclk_tlast),
    .aclk_tdata(aclk_tdata)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  user;
    logic        last;
  } beat_t;

  typedef struct {
    string name;
    int    x;
    int    y;
    int    gap;
    bit    bp;
    int    beats;
    int    first_u;
    int    last_u;
  } vec_t;

  beat_t exp_q[$];
  vec_t  tbl[6];

  int total = 0;
  int bad = 0;
  bit bp_mode = 0;
  int acc_cnt = 0;
  int done_cnt = 0;
  int frame_beats = 0;
  int exp_gap = 0;
  int idle = 0;
  int first_u = 0;
  int last_u = 0;
  bit gap_cnting = 0;
  bit pend_done = 0;
  bit stall = 0;
  logic [68:0] held = '0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Expected beats straight from the frame definition
  task automatic push_frame(input int x, input int y);
    int bpl;
    int ny;
    beat_t e;
    bpl = x / 8;
    if (bpl == 0) bpl = 1;
    ny = (y == 0) ? 1 : y;
    for (int l = 0; l < ny; l++) begin
      for (int b = 0; b < bpl; b++) begin
        for (int k = 0; k < 8; k++) e.data[8*k +: 8] = 8'((8*b + k) % 256);
        e.user = 4'h0;
        if (b == 0)       e.user = e.user | ((l == 0) ? 4'h1 : 4'h4);
        if (b == bpl - 1) e.user = e.user | ((l == ny - 1) ? 4'h2 : 4'h8);
        e.last = (b == bpl - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  always @(negedge aclk) begin
    beat_t e;
    if (stall) begin
      check("hold_tvalid", 128'(aclk_tvalid), 128'(1));
      check("hold_beat", 128'({aclk_tlast, aclk_tuser, aclk_tdata}), 128'(held));
    end
    stall = 0;
    if (aclk_frame_done) done_cnt++;
    if (pend_done) begin
      check("frame_done", 128'(aclk_frame_done), 128'(1));
      check("busy_after_eof", 128'(aclk_busy), 128'(0));
      check("tvalid_after_eof", 128'(aclk_tvalid), 128'(0));
      pend_done = 0;
    end else if (aclk_frame_done) begin
      total++;
      bad++;
      $display("FAIL frame_done_unexpected: got 1 expected 0");
    end
    if (gap_cnting) begin
      if (aclk_tvalid) begin
        check("line_gap", 128'(idle), 128'(exp_gap));
        gap_cnting = 0;
      end else idle++;
    end
    if (aclk_tvalid && aclk_tready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL beat_extra: got tdata 0x%0h expected no beat", aclk_tdata);
      end else begin
        e = exp_q.pop_front();
        check("tdata", 128'(aclk_tdata), 128'(e.data));
        check("tuser", 128'(aclk_tuser), 128'(e.user));
        check("tlast", 128'(aclk_tlast), 128'(e.last));
      end
      if (frame_beats == 0) first_u = int'(aclk_tuser);
      last_u = int'(aclk_tuser);
      frame_beats++;
      acc_cnt++;
      if (aclk_tuser[1]) pend_done = 1;
      else if (aclk_tlast) begin
        gap_cnting = 1;
        idle = 0;
      end
    end else if (aclk_tvalid) begin
      stall = 1;
      held = {aclk_tlast, aclk_tuser, aclk_tdata};
    end
  end

  initial begin
    forever begin
      @(posedge aclk);
      #1;
      aclk_tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic pulse_start();
    @(posedge aclk);
    #1 aclk_start = 1'b1;
    @(posedge aclk);
    #1 aclk_start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge aclk);
      n++;
    end
    if (done_cnt == d0) begin
      total++;
      bad++;
      $display("FAIL frame_timeout: got no frame_done expected one within %0d cycles", budget);
      exp_q.delete();
    end
  endtask

  task automatic run_frame(input vec_t v);
    int d0;
    aclk_x_size   = XW'(v.x);
    aclk_y_size   = YW'(v.y);
    aclk_line_gap = XW'(v.gap);
    exp_gap       = v.gap;
    bp_mode       = v.bp;
    frame_beats   = 0;
    d0            = done_cnt;
    push_frame(v.x, v.y);
    pulse_start();
    wait_done(d0, 5000);
    bp_mode = 0;
    repeat (2) @(posedge aclk);
    check({v.name, "_beats"}, 128'(frame_beats), 128'(v.beats));
    check({v.name, "_first_tuser"}, 128'(first_u), 128'(v.first_u));
    check({v.name, "_last_tuser"}, 128'(last_u), 128'(v.last_u));
    check({v.name, "_queue_empty"}, 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    int d0;
    int n;
    int a0;
    int vcnt;
    tbl[0] = '{"nominal",   1024, 4, 100, 1'b0, 512, 1, 2};
    tbl[1] = '{"backpress",   64, 2,   0, 1'b1,  16, 1, 2};
    tbl[2] = '{"x8_y3",        8, 3,   2, 1'b0,   3, 9, 6};
    tbl[3] = '{"x5_y0",        5, 0,   0, 1'b0,   1, 3, 3};
    tbl[4] = '{"x8_y1_bp",     8, 1,   0, 1'b1,   1, 3, 3};
    tbl[5] = '{"x20_y2_bp",   20, 2,   1, 1'b1,   4, 1, 2};

    repeat (3) @(posedge aclk);
    #1 aclk_reset = 1'b0;
    @(negedge aclk);
    check("rst_tvalid", 128'(aclk_tvalid), 128'(0));
    check("rst_busy", 128'(aclk_busy), 128'(0));
    check("rst_done", 128'(aclk_frame_done), 128'(0));
    check("rst_tuser", 128'(aclk_tuser), 128'(0));
    check("rst_tdata", 128'(aclk_tdata), 128'(0));

    for (int i = 0; i < 6; i++) run_frame(tbl[i]);

    // Start re-pulsed and x_size changed mid-frame: only the first frame appears
    aclk_x_size = 16'd64; aclk_y_size = 16'd2; aclk_line_gap = 16'd3;
    exp_gap = 3; frame_beats = 0; d0 = done_cnt;
    push_frame(64, 2);
    pulse_start();
    repeat (4) @(posedge aclk);
    #1 aclk_x_size = 16'd16;
    pulse_start();
    wait_done(d0, 2000);
    vcnt = 0;
    repeat (20) begin
      @(negedge aclk);
      if (aclk_tvalid) vcnt++;
    end
    check("restart_beats", 128'(frame_beats), 128'(16));
    check("restart_no_second_frame", 128'(vcnt), 128'(0));
    check("restart_queue_empty", 128'(exp_q.size()), 128'(0));

    // Reset while line 1 beat 10 is presented
    aclk_x_size = 16'd128; aclk_y_size = 16'd3; aclk_line_gap = 16'd2;
    exp_gap = 2; frame_beats = 0; a0 = acc_cnt;
    push_frame(128, 3);
    pulse_start();
    n = 0;
    while (acc_cnt - a0 < 26 && n < 500) begin
      @(negedge aclk);
      n++;
    end
    check("reset_reach_beat", 128'(acc_cnt - a0), 128'(26));
    @(posedge aclk);
    #1 aclk_reset = 1'b1;
    @(posedge aclk);
    #1 aclk_reset = 1'b0;
    @(negedge aclk);
    check("midrst_tvalid", 128'(aclk_tvalid), 128'(0));
    check("midrst_busy", 128'(aclk_busy), 128'(0));
    check("midrst_done", 128'(aclk_frame_done), 128'(0));
    exp_q.delete();
    gap_cnting = 0;
    pend_done = 0;
    repeat (5) @(negedge aclk);
    run_frame('{"after_reset", 128, 3, 2, 1'b0, 48, 1, 2});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
